// File: rtl/wb_io_bank.sv
// wb_io_bank: Wishbone register bank for N LEDs and N active-low push-buttons.
// Provides per-button debounce, sticky press events with a level interrupt,
// and hardware LED blinking driven by a programmable prescaler.
module wb_io_bank #(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int unsigned N_LEDS          = 4,
  parameter int unsigned N_BTNS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned BLINK_DIV_W     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [31:0]       i_wb_addr,
  input  logic [31:0]       i_wb_data,
  output logic              o_wb_ack,
  output logic              o_wb_stall,
  output logic [31:0]       o_wb_data,
  input  logic [N_BTNS-1:0] buttons,
  output logic [N_BTNS-1:0] buttons_enb,
  output logic [N_LEDS-1:0] led_enb,
  output logic [N_LEDS-1:0] leds,
  output logic              o_irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] REG_LED_OUT   = 3'd0;
  localparam logic [2:0] REG_BLINK_EN  = 3'd1;
  localparam logic [2:0] REG_BTN_STATE = 3'd2;
  localparam logic [2:0] REG_BTN_EVENT = 3'd3;
  localparam logic [2:0] REG_IRQ_EN    = 3'd4;
  localparam logic [2:0] REG_PERIOD    = 3'd5;

  // Bus decode
  logic [31:0] offset_s;
  logic [2:0]  idx_s;
  logic        hit_s;
  logic        acc_s;
  logic        wr_s;
  logic        rd_s;
  logic        unused_bits_s;

  // Architectural registers
  logic [N_LEDS-1:0]      led_out_q, led_out_d;
  logic [N_LEDS-1:0]      blink_en_q, blink_en_d;
  logic [N_BTNS-1:0]      btn_event_q, btn_event_d;
  logic [N_BTNS-1:0]      irq_en_q, irq_en_d;
  logic [BLINK_DIV_W-1:0] period_q, period_d;
  logic [N_BTNS-1:0]      w1c_s;
  logic                   period_wr_s;

  // Button path
  logic [N_BTNS-1:0] sync1_q, sync2_q;
  logic [N_BTNS-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]  cnt_q [N_BTNS];
  logic [CNT_W-1:0]  cnt_d [N_BTNS];

  // Blink path and outputs
  logic [BLINK_DIV_W-1:0] presc_q, presc_d;
  logic                   phase_q, phase_d;
  logic [N_LEDS-1:0]      leds_q, leds_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            rd_val_s;
  logic                   irq_q, irq_d;

  // Offset arithmetic wraps, so addresses below BASE_ADDR land far out of window.
  assign offset_s = i_wb_addr - BASE_ADDR;
  assign idx_s    = offset_s[4:2];
  assign hit_s    = (offset_s[31:5] == 27'd0) && (offset_s[1:0] == 2'b00) && (idx_s <= REG_PERIOD);
  assign acc_s    = i_wb_cyc & i_wb_stb & hit_s;
  assign wr_s     = acc_s & i_wb_we;
  assign rd_s     = acc_s & ~i_wb_we;

  assign unused_bits_s = ^{i_wb_data, offset_s};

  assign o_wb_stall  = 1'b0;
  assign buttons_enb = {N_BTNS{1'b1}};
  assign led_enb     = {N_LEDS{1'b0}};
  assign o_wb_ack    = ack_q;
  assign o_wb_data   = rdata_q;
  assign leds        = leds_q;
  assign o_irq       = irq_q;

  // Read multiplexer: zero-extend each register to the bus width.
  always_comb begin
    rd_val_s = 32'd0;
    case (idx_s)
      REG_LED_OUT:   rd_val_s = 32'(led_out_q);
      REG_BLINK_EN:  rd_val_s = 32'(blink_en_q);
      REG_BTN_STATE: rd_val_s = 32'(deb_q);
      REG_BTN_EVENT: rd_val_s = 32'(btn_event_q);
      REG_IRQ_EN:    rd_val_s = 32'(irq_en_q);
      REG_PERIOD:    rd_val_s = 32'(period_q);
      default:       rd_val_s = 32'd0;
    endcase
  end

  // Register write decode; BTN_STATE writes are acked but have no effect.
  always_comb begin
    led_out_d   = led_out_q;
    blink_en_d  = blink_en_q;
    irq_en_d    = irq_en_q;
    period_d    = period_q;
    w1c_s       = {N_BTNS{1'b0}};
    period_wr_s = 1'b0;
    if (wr_s) begin
      case (idx_s)
        REG_LED_OUT:   led_out_d  = i_wb_data[N_LEDS-1:0];
        REG_BLINK_EN:  blink_en_d = i_wb_data[N_LEDS-1:0];
        REG_BTN_EVENT: w1c_s      = i_wb_data[N_BTNS-1:0];
        REG_IRQ_EN:    irq_en_d   = i_wb_data[N_BTNS-1:0];
        REG_PERIOD: begin
          period_d    = i_wb_data[BLINK_DIV_W-1:0];
          period_wr_s = 1'b1;
        end
        default: begin
          led_out_d = led_out_q;
        end
      endcase
    end else begin
      period_wr_s = 1'b0;
    end
  end

  // Debounce counters: debounced bit follows the synchronised input after a stable run.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < int'(N_BTNS); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1'b1);
      end
    end
  end

  // Event flags, interrupt, blink prescaler, LED drive and bus response next state.
  always_comb begin
    // A new press overrides a simultaneous write-one-to-clear on the same bit.
    btn_event_d = (btn_event_q & ~w1c_s) | (deb_d & ~deb_q);
    irq_d       = |(btn_event_q & irq_en_q);
    presc_d     = presc_q;
    phase_d     = phase_q;
    if (period_wr_s) begin
      presc_d = '0;
      phase_d = 1'b0;
    end else if (presc_q == period_q) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + BLINK_DIV_W'(1'b1);
    end
    leds_d  = led_out_q & ~(blink_en_q & {N_LEDS{phase_q}});
    ack_d   = acc_s;
    if (rd_s) begin
      rdata_d = rd_val_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Bus-visible registers and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out_q   <= '0;
      blink_en_q  <= '0;
      btn_event_q <= '0;
      irq_en_q    <= '0;
      period_q    <= '1;
      presc_q     <= '0;
      phase_q     <= 1'b0;
      leds_q      <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      led_out_q   <= led_out_d;
      blink_en_q  <= blink_en_d;
      btn_event_q <= btn_event_d;
      irq_en_q    <= irq_en_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      leds_q      <= leds_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  // Button synchroniser (inverting the active-low pads) and debounce state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < int'(N_BTNS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= ~buttons;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < int'(N_BTNS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_io_bank.sv
// Directed testbench for wb_io_bank with a read/ack scoreboard.
module tb_wb_io_bank;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        reset;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;
  logic [3:0]  buttons;
  logic [3:0]  buttons_enb;
  logic [3:0]  led_enb;
  logic [3:0]  leds;
  logic        o_irq;

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  wb_io_bank #(
    .BASE_ADDR(BASE),
    .N_LEDS(4),
    .N_BTNS(4),
    .DEBOUNCE_CYCLES(8),
    .BLINK_DIV_W(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_wb_cyc(i_wb_cyc),
    .i_wb_stb(i_wb_stb),
    .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack),
    .o_wb_stall(o_wb_stall),
    .o_wb_data(o_wb_data),
    .buttons(buttons),
    .buttons_enb(buttons_enb),
    .led_enb(led_enb),
    .leds(leds),
    .o_irq(o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic mapped(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o < 32'd24) && (o[1:0] == 2'b00);
  endfunction

  // Compare the bus response against the oldest expectation, if any.
  task automatic chk_bus();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ack", 32'(o_wb_ack), 32'd1);
      if (e.rd) check("rdata", o_wb_data, e.data);
    end else begin
      check("ack_idle", 32'(o_wb_ack), 32'd0);
    end
  endtask

  // One bus cycle: check previous response at the falling edge, then drive new request.
  task automatic step(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp_rd);
    exp_t e;
    @(negedge clk);
    chk_bus();
    i_wb_cyc  = req;
    i_wb_stb  = req;
    i_wb_we   = we;
    i_wb_addr = addr;
    i_wb_data = data;
    if (req && mapped(addr)) begin
      e.rd   = ~we;
      e.data = exp_rd;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp);
    step(1'b1, 1'b0, BASE + off, 32'd0, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    step(1'b1, 1'b1, BASE + off, d, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    i_wb_cyc  = 1'b0;
    i_wb_stb  = 1'b0;
    i_wb_we   = 1'b0;
    i_wb_addr = 32'd0;
    i_wb_data = 32'd0;
    buttons   = 4'hF;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_ack", 32'(o_wb_ack), 32'd0);
    check("rst_irq", 32'(o_irq), 32'd0);
    check("rst_rdata", o_wb_data, 32'd0);
    check("led_enb", 32'(led_enb), 32'd0);
    check("buttons_enb", 32'(buttons_enb), 32'hF);
    check("stall", 32'(o_wb_stall), 32'd0);
    reset = 1'b0;
    rd(32'h14, 32'h00FF_FFFF);
    idle();

    // LED write latency and readback
    wr(32'h00, 32'hF);
    idle();
    check("leds_1cyc", 32'(leds), 32'd0);
    idle();
    check("leds_2cyc", 32'(leds), 32'hF);
    rd(32'h00, 32'hF);
    idle();

    // Enable button 0 interrupt
    wr(32'h10, 32'h1);
    idle();

    // Short glitch is filtered
    for (int j = 0; j < 16; j++) begin
      rd(32'h08, 32'd0);
      if (j == 0) buttons[0] = 1'b0;
      if (j == 5) buttons[0] = 1'b1;
    end
    rd(32'h0C, 32'd0);
    idle();
    check("irq_glitch", 32'(o_irq), 32'd0);

    // Long press: state changes 10 cycles after pad edge, event and irq follow
    for (int j = 0; j < 20; j++) begin
      rd(32'h08, (j >= 10) ? 32'd1 : 32'd0);
      if (j == 0) buttons[0] = 1'b0;
      check("irq_press", 32'(o_irq), (j >= 11) ? 32'd1 : 32'd0);
    end
    rd(32'h0C, 32'd1);

    // Release sets no event; flag is sticky
    buttons[0] = 1'b1;
    repeat (12) idle();
    rd(32'h08, 32'd0);
    rd(32'h0C, 32'd1);
    idle();
    check("irq_sticky", 32'(o_irq), 32'd1);

    // W1C clears the flag and the interrupt one cycle later
    wr(32'h0C, 32'h1);
    idle();
    check("irq_w1c_1", 32'(o_irq), 32'd1);
    idle();
    check("irq_w1c_2", 32'(o_irq), 32'd0);
    rd(32'h0C, 32'd0);

    // Press coincident with W1C: set wins
    idle();
    buttons[0] = 1'b0;
    for (int j = 1; j < 9; j++) idle();
    wr(32'h0C, 32'h1);
    idle();
    rd(32'h0C, 32'd1);
    buttons[0] = 1'b1;
    repeat (12) idle();

    // Blink: period 3 toggles phase every 4 cycles
    wr(32'h00, 32'h1);
    wr(32'h04, 32'h1);
    wr(32'h14, 32'h3);
    for (int t = 1; t < 18; t++) begin
      idle();
      if (t >= 2) check("blink", 32'(leds), ((((t - 2) / 4) % 2) == 0) ? 32'd1 : 32'd0);
    end
    wr(32'h00, 32'h0);
    for (int t = 1; t < 11; t++) begin
      idle();
      if (t >= 2) check("blink_off", 32'(leds), 32'd0);
    end

    // Out-of-window accesses: no ack, no state change, read data holds
    rd(32'h04, 32'd1);
    idle();
    step(1'b1, 1'b1, BASE + 32'h18, 32'hF, 32'd0);
    step(1'b1, 1'b1, BASE - 32'h4, 32'hF, 32'd0);
    step(1'b1, 1'b1, BASE + 32'h20, 32'hF, 32'd0);
    step(1'b1, 1'b0, BASE + 32'h18, 32'd0, 32'd0);
    idle();
    check("rdata_hold", o_wb_data, 32'd1);
    rd(32'h00, 32'd0);
    rd(32'h04, 32'd1);
    rd(32'h10, 32'd1);
    rd(32'h14, 32'd3);
    rd(32'h0C, 32'd1);

    // Back-to-back accesses, BTN_STATE write ignored
    wr(32'h00, 32'h5);
    rd(32'h00, 32'd5);
    wr(32'h10, 32'h0);
    rd(32'h10, 32'd0);
    wr(32'h08, 32'hF);
    rd(32'h08, 32'd0);
    wr(32'h04, 32'h0);
    wr(32'h10, 32'h1);
    idle();
    idle();
    check("leds_pre_rst", 32'(leds), 32'd5);
    check("irq_pre_rst", 32'(o_irq), 32'd1);

    // Async reset mid-transaction drops the pending ack
    @(negedge clk);
    chk_bus();
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = 1'b0;
    i_wb_addr = BASE + 32'h00;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_ack", 32'(o_wb_ack), 32'd0);
    check("rst_mid_leds", 32'(leds), 32'd0);
    check("rst_mid_irq", 32'(o_irq), 32'd0);
    check("rst_mid_rdata", o_wb_data, 32'd0);
    @(negedge clk);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    reset    = 1'b0;
    exp_q.delete();
    rd(32'h14, 32'h00FF_FFFF);
    rd(32'h00, 32'd0);
    rd(32'h0C, 32'd0);
    rd(32'h10, 32'd0);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
